key_irq_controller: RTL and testbench

- Front end for the core's external interrupt path.
- Conditions the raw KEY push-buttons: synchronise, debounce and falling-edge detect.
- Latches one pending bit per line and applies the Status mask bits and the global IE bit.
- Drives a single prioritised interrupt request, a line id and a Cause value into the decode-stage Cause/EPC/Status logic; the core acknowledges each request to clear it.

---
 rtl/key_irq_controller_pkg.sv | 11 +
 rtl/key_irq_controller_debounce.sv | 35 +++
 rtl/key_irq_controller.sv | 44 ++++
 tb/tb_key_irq_controller.sv | 113 +++++++++++
 4 files changed

// File: rtl/key_irq_controller_pkg.sv
// key_irq_controller_pkg: shared constants and helpers for the external key interrupt path.
package key_irq_controller_pkg;
   localparam int KEY_IRQ_CAUSE_SHIFT = 8;
   localparam int MAX_KEYS = 4;
   localparam int IRQ_ID_W = 2;
   localparam logic [29:0] EXC_VECTOR = 30'h60;
   typedef logic [IRQ_ID_W-1:0] irq_id_t;
   function automatic logic [31:0] irq_cause(irq_id_t id);
      return 32'(1) << (KEY_IRQ_CAUSE_SHIFT + int'(id));
   endfunction
endpackage

// File: rtl/key_irq_controller_debounce.sv
// key_debounce: synchronises one raw key, debounces it and emits a one-cycle press pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic key_i,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0] sync_q;
   logic stable_q, stable_d, prev_q, s, done;
   logic [CW-1:0] cnt_q, cnt_d;
   // Normalised before sampling so 1 = pressed and reset value 0 = released.
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], key_i ^ KEY_ACTIVE_LOW};
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   always_comb begin
      s        = sync_q[1];
      done     = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
      stable_d = (s != stable_q && done) ? s : stable_q;
      cnt_d    = (s == stable_q || done) ? '0 : cnt_q + 1'b1;
   end
   assign press_o = stable_q & ~prev_q;
endmodule

// File: rtl/key_irq_controller.sv
// key_irq_controller: latches debounced key presses as pending interrupts and raises a prioritised request.
module key_irq_controller
   import key_irq_controller_pkg::*;
#(
   parameter int N_KEYS = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] KEY,
   input  logic [N_KEYS-1:0] i_mask,
   input  logic              i_ie,
   input  logic              i_ack,
   input  logic [1:0]        i_ack_id,
   output logic [N_KEYS-1:0] o_pending,
   output logic              o_irq,
   output logic [1:0]        o_irq_id,
   output logic [31:0]       o_cause
);
   logic [N_KEYS-1:0] press, clr, eff, pending_q, pending_d;
   irq_id_t id;
   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_db (
         .Clk(Clk), .Reset(Reset), .key_i(KEY[g]), .press_o(press[g])
      );
   end
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) pending_q <= '0;
      else pending_q <= pending_d;
   // Acks for ids beyond N_KEYS match no line; a new press overrides a same-cycle ack.
   always_comb begin
      clr = '0;
      for (int k = 0; k < N_KEYS; k++) clr[k] = i_ack && i_ack_id == IRQ_ID_W'(k);
      pending_d = (pending_q & ~clr) | press;
      eff = i_ie ? (pending_q & i_mask) : '0;
      id = '0;
      for (int k = N_KEYS - 1; k >= 0; k--) if (eff[k]) id = IRQ_ID_W'(k);
   end
   assign o_pending = pending_q;
   assign o_irq     = |eff;
   assign o_irq_id  = id;
   assign o_cause   = o_irq ? irq_cause(id) : '0;
endmodule

// File: tb/tb_key_irq_controller.sv
// tb_key_irq_controller: directed checks of debounce latency, pending, masking, priority and ack.
module tb_key_irq_controller;
   logic Clk = 1'b0, Reset = 1'b0, i_ie = 1'b0, i_ack = 1'b0, o_irq;
   logic [3:0] KEY = 4'hF, i_mask = 4'h0, o_pending;
   logic [1:0] i_ack_id = 2'd0, o_irq_id;
   logic [31:0] o_cause;
   int n_tests = 0, n_fail = 0;

   key_irq_controller #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1'b1)) dut (
      .Clk(Clk), .Reset(Reset), .KEY(KEY), .i_mask(i_mask), .i_ie(i_ie), .i_ack(i_ack),
      .i_ack_id(i_ack_id), .o_pending(o_pending), .o_irq(o_irq), .o_irq_id(o_irq_id), .o_cause(o_cause)
   );

   always #5 Clk = ~Clk;

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic ack(input logic [1:0] id);
      i_ack = 1'b1; i_ack_id = id;
      step(1);
      i_ack = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      n_tests++; if ({o_pending, o_irq, o_irq_id, o_cause} !== 39'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", {o_pending, o_irq, o_irq_id, o_cause}); end
      step(2); Reset = 1'b1; step(2);
      KEY[0] = 1'b0; step(3);
      Reset = 1'b0; #1;
      n_tests++; if (o_pending !== 4'h0 || o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_midcount pending %b irq %b want 0000 0", o_pending, o_irq); end
      step(3); Reset = 1'b1;
      step(6);
      n_tests++; if (o_pending !== 4'h0) begin n_fail++; $display("FAIL reset_early pending %b want 0000", o_pending); end
      step(1);
      n_tests++; if (o_pending !== 4'b0001) begin n_fail++; $display("FAIL reset_latency pending %b want 0001", o_pending); end
      n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_masked_irq got %b want 0", o_irq); end
      KEY[0] = 1'b1; ack(2'd0);
      n_tests++; if (o_pending !== 4'h0) begin n_fail++; $display("FAIL reset_ack pending %b want 0000", o_pending); end
      step(8);
      n_tests++; if (o_pending !== 4'h0) begin n_fail++; $display("FAIL release_no_pending pending %b want 0000", o_pending); end
   endtask

   task automatic test_irq_line1;
      i_mask = 4'hF; i_ie = 1'b1; KEY[1] = 1'b0;
      step(6);
      n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL line1_early irq %b want 0", o_irq); end
      step(1);
      n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd1) begin n_fail++; $display("FAIL line1_irq irq %b id %0d want 1 1", o_irq, o_irq_id); end
      n_tests++; if (o_cause !== 32'h0000_0200) begin n_fail++; $display("FAIL line1_cause got %h want 00000200", o_cause); end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 4; i++) begin
         KEY[2] = i[0]; step(1);
         n_tests++; if (o_pending[2] !== 1'b0) begin n_fail++; $display("FAIL bounce_%0d pending2 %b want 0", i, o_pending[2]); end
      end
      KEY[2] = 1'b0;
      step(6);
      n_tests++; if (o_pending[2] !== 1'b0) begin n_fail++; $display("FAIL bounce_early pending2 %b want 0", o_pending[2]); end
      step(1);
      n_tests++; if (o_pending !== 4'b0110) begin n_fail++; $display("FAIL bounce_set pending %b want 0110", o_pending); end
      n_tests++; if (o_irq_id !== 2'd1) begin n_fail++; $display("FAIL bounce_prio id %0d want 1", o_irq_id); end
      KEY = 4'hF; ack(2'd2);
      n_tests++; if (o_pending !== 4'b0010) begin n_fail++; $display("FAIL ack2 pending %b want 0010", o_pending); end
      step(8);
   endtask

   task automatic test_priority;
      KEY[3] = 1'b0; step(7);
      n_tests++; if (o_pending !== 4'b1010 || o_irq_id !== 2'd1 || o_cause !== 32'h200) begin n_fail++; $display("FAIL prio_both pending %b id %0d cause %h want 1010 1 00000200", o_pending, o_irq_id, o_cause); end
      ack(2'd1);
      n_tests++; if (o_pending !== 4'b1000 || o_irq_id !== 2'd3 || o_cause !== 32'h800) begin n_fail++; $display("FAIL prio_after_ack1 pending %b id %0d cause %h want 1000 3 00000800", o_pending, o_irq_id, o_cause); end
      ack(2'd3);
      n_tests++; if (o_irq !== 1'b0 || o_pending !== 4'h0 || o_cause !== 32'h0 || o_irq_id !== 2'd0) begin n_fail++; $display("FAIL prio_after_ack3 irq %b pending %b id %0d cause %h want 0 0000 0 0", o_irq, o_pending, o_irq_id, o_cause); end
      KEY[3] = 1'b1; step(8);
   endtask

   task automatic test_mask;
      i_mask = 4'b1110; KEY[0] = 1'b0; step(7);
      n_tests++; if (o_pending !== 4'b0001 || o_irq !== 1'b0) begin n_fail++; $display("FAIL mask_hidden pending %b irq %b want 0001 0", o_pending, o_irq); end
      i_mask = 4'hF; #1;
      n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd0 || o_cause !== 32'h100) begin n_fail++; $display("FAIL mask_unmask irq %b id %0d cause %h want 1 0 00000100", o_irq, o_irq_id, o_cause); end
      i_ie = 1'b0; #1;
      n_tests++; if (o_irq !== 1'b0 || o_cause !== 32'h0) begin n_fail++; $display("FAIL ie_off irq %b cause %h want 0 0", o_irq, o_cause); end
      i_ie = 1'b1;
   endtask

   task automatic test_back_to_back;
      KEY[0] = 1'b1; step(8);
      KEY[0] = 1'b0; step(6);
      n_tests++; if (o_pending !== 4'b0001) begin n_fail++; $display("FAIL repress_absorb pending %b want 0001", o_pending); end
      ack(2'd0);
      n_tests++; if (o_pending !== 4'b0001) begin n_fail++; $display("FAIL set_wins pending %b want 0001", o_pending); end
      ack(2'd3);
      n_tests++; if (o_pending !== 4'b0001 || o_irq !== 1'b1 || o_irq_id !== 2'd0) begin n_fail++; $display("FAIL idle_ack3 pending %b irq %b id %0d want 0001 1 0", o_pending, o_irq, o_irq_id); end
      ack(2'd0);
      n_tests++; if (o_pending !== 4'h0 || o_irq !== 1'b0) begin n_fail++; $display("FAIL final_ack0 pending %b irq %b want 0000 0", o_pending, o_irq); end
   endtask

   initial begin
      test_reset;
      test_irq_line1;
      test_bounce;
      test_priority;
      test_mask;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
